// File: rtl/usb_serial_tx_fifo.sv
// usb_serial_tx_fifo
//   Byte FIFO in front of the USB serial endpoint's uart-side transmit port.
//   Absorbs producer bursts and meters bytes out one strobe at a time,
//   leaving a gap cycle after every strobe. The endpoint deasserts ready
//   one cycle late, so this gap keeps a second load from overwriting the
//   byte it is holding.
//
// Ports
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   wr_data         : byte from producer
//   wr_strobe       : write request, sampled every cycle
//   wr_ready        : FIFO not full
//   wr_almost_full  : count >= AFULL_LEVEL
//   flush           : synchronous clear of contents (status is kept)
//   count           : occupancy 0..DEPTH
//   overflow        : sticky, set when a write is dropped
//   drop_count      : saturating count of dropped writes
//   uart_tx_ready   : endpoint can accept a byte
//   uart_tx_data    : byte to endpoint, held between strobes
//   uart_tx_strobe  : one-cycle load pulse to endpoint
module usb_serial_tx_fifo #(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned AFULL_LEVEL = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            wr_data,
  input  logic                  wr_strobe,
  output logic                  wr_ready,
  output logic                  wr_almost_full,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  input  logic                  uart_tx_ready,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_strobe
);

  localparam int unsigned          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]  DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]  AFULL_CNT = (DEPTH_LOG2 + 1)'(AFULL_LEVEL);

  logic [7:0]            mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_count_q, drop_count_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_strobe_q, tx_strobe_d;

  logic full;
  logic wr_accept;
  logic wr_drop;
  logic launch;

  // Full is judged on the pre-edge count; a launch in the same cycle does
  // not make room for a write.
  assign full      = (count_q == DEPTH_CNT);
  assign wr_accept = wr_strobe && !full && !flush;
  assign wr_drop   = wr_strobe &&  full && !flush;
  // !tx_strobe_q forces a gap cycle while the endpoint's ready is still
  // catching up with the previous load.
  assign launch    = (count_q != '0) && uart_tx_ready && !tx_strobe_q && !flush;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    tx_data_d    = tx_data_q;
    tx_strobe_d  = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (launch) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        tx_data_d   = mem_q[rd_ptr_q];
        tx_strobe_d = 1'b1;
      end
      if (wr_accept && !launch) begin
        count_d = count_q + 1'b1;
      end else if (launch && !wr_accept) begin
        count_d = count_q - 1'b1;
      end
      if (wr_drop) begin
        overflow_d = 1'b1;
        if (drop_count_q != '1) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      tx_data_q    <= '0;
      tx_strobe_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      tx_data_q    <= tx_data_d;
      tx_strobe_q  <= tx_strobe_d;
    end
  end

  // Storage needs no reset; the pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign wr_ready       = !full;
  assign wr_almost_full = (count_q >= AFULL_CNT);
  assign count          = count_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_count_q;
  assign uart_tx_data   = tx_data_q;
  assign uart_tx_strobe = tx_strobe_q;

endmodule

// File: tb/tb_usb_serial_tx_fifo.sv
// Bench for usb_serial_tx_fifo: directed stimulus pushes expected bytes into
// a scoreboard queue; an independent monitor pops and compares on every
// uart_tx_strobe and checks strobe spacing against the endpoint ready.
module tb_usb_serial_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       wr_ready;
  logic       wr_almost_full;
  logic       flush;
  logic [6:0] count;
  logic       overflow;
  logic [7:0] drop_count;
  logic       uart_tx_ready;
  logic [7:0] uart_tx_data;
  logic       uart_tx_strobe;

  logic       ready_force;
  logic       ep_mode;
  logic       ep_held;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned strobes_seen = 0;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  assign uart_tx_ready = ep_mode ? !ep_held : ready_force;

  usb_serial_tx_fifo #(.DEPTH_LOG2(6), .AFULL_LEVEL(60)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_data        (wr_data),
    .wr_strobe      (wr_strobe),
    .wr_ready       (wr_ready),
    .wr_almost_full (wr_almost_full),
    .flush          (flush),
    .count          (count),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .uart_tx_ready  (uart_tx_ready),
    .uart_tx_data   (uart_tx_data),
    .uart_tx_strobe (uart_tx_strobe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Endpoint model: ready = !held; held set on load, cleared 3 cycles later.
  initial begin
    int unsigned hold_cnt;
    hold_cnt = 0;
    ep_held  = 1'b0;
    forever begin
      cyc();
      if (!ep_mode) begin
        ep_held  = 1'b0;
        hold_cnt = 0;
      end else if (uart_tx_strobe) begin
        ep_held  = 1'b1;
        hold_cnt = 3;
      end else if (hold_cnt != 0) begin
        hold_cnt--;
        if (hold_cnt == 0) ep_held = 1'b0;
      end
    end
  end

  // Monitor: inputs change just after posedge, so the value seen at a
  // negedge is what the DUT samples at the following posedge.
  initial begin
    logic prev_ready;
    logic prev_strobe;
    logic [7:0] e;
    prev_ready  = 1'b0;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_tx_strobe === 1'b1) begin
        strobes_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'(uart_tx_data), 32'h100);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(uart_tx_data), 32'(e));
        end
        chk("strobe_gap", 32'(prev_strobe), 32'd0);
        chk("strobe_ready", 32'(prev_ready), 32'd1);
      end
      prev_strobe = uart_tx_strobe;
      prev_ready  = uart_tx_ready;
    end
  end

  task automatic write(input logic [7:0] b, input bit push);
    wr_data   = b;
    wr_strobe = 1'b1;
    if (push) exp_q.push_back(b);
    cyc();
    wr_strobe = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      cyc();
      n++;
    end
    repeat (4) cyc();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int unsigned k;
    int unsigned guard;
    int unsigned seen0;
    reset       = 1'b1;
    wr_data     = '0;
    wr_strobe   = 1'b0;
    flush       = 1'b0;
    ready_force = 1'b0;
    ep_mode     = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;

    // Reset state and idle
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_afull", 32'(wr_almost_full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_strobe", 32'(uart_tx_strobe), 32'd0);
    chk("rst_data", 32'(uart_tx_data), 32'd0);
    repeat (5) cyc();
    chk("idle_strobes", 32'(strobes_seen), 32'd0);

    // Single byte latency
    ready_force = 1'b1;
    write(8'hA5, 1'b1);
    chk("lat_k_strobe", 32'(uart_tx_strobe), 32'd0);
    chk("lat_k_count", 32'(count), 32'd1);
    cyc();
    chk("lat_k1_strobe", 32'(uart_tx_strobe), 32'd1);
    chk("lat_k1_data", 32'(uart_tx_data), 32'hA5);
    chk("lat_k1_count", 32'(count), 32'd0);
    cyc();
    chk("lat_k2_strobe", 32'(uart_tx_strobe), 32'd0);
    chk("lat_hold_data", 32'(uart_tx_data), 32'hA5);

    // Fill to full with endpoint blocked, then overflow
    ready_force = 1'b0;
    for (int i = 0; i < 64; i++) begin
      write(8'(i), 1'b1);
      if (i == 58) chk("afull_at_59", 32'(wr_almost_full), 32'd0);
      if (i == 59) chk("afull_at_60", 32'(wr_almost_full), 32'd1);
    end
    chk("full_count", 32'(count), 32'd64);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    write(8'hFF, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd1);
    chk("ovf_count", 32'(count), 32'd64);
    ep_mode = 1'b1;
    wait_drain(1000);
    chk("drain_count", 32'(count), 32'd0);

    // Continuous flow-controlled writes against the endpoint model
    ep_mode = 1'b0;
    for (int i = 0; i < 64; i++) write(8'(8'h40 + i), 1'b1);
    chk("refill_count", 32'(count), 32'd64);
    ep_mode = 1'b1;
    k = 0;
    guard = 0;
    while (k < 100 && guard < 2000) begin
      if (wr_ready) begin
        wr_data   = 8'(k * 7 + 3);
        wr_strobe = 1'b1;
        exp_q.push_back(8'(k * 7 + 3));
        k++;
      end else begin
        wr_strobe = 1'b0;
      end
      cyc();
      guard++;
    end
    wr_strobe = 1'b0;
    chk("stream_sent", 32'(k), 32'd100);
    wait_drain(2000);
    chk("stream_drop", 32'(drop_count), 32'd1);

    // Flush with simultaneous write
    ep_mode     = 1'b0;
    ready_force = 1'b0;
    cyc();
    for (int i = 0; i < 10; i++) write(8'(8'h60 + i), 1'b0);
    chk("preflush_count", 32'(count), 32'd10);
    flush     = 1'b1;
    wr_strobe = 1'b1;
    wr_data   = 8'h77;
    cyc();
    flush     = 1'b0;
    wr_strobe = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_drop", 32'(drop_count), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd1);
    seen0 = strobes_seen;
    ready_force = 1'b1;
    repeat (10) cyc();
    chk("flush_no_strobe", 32'(strobes_seen - seen0), 32'd0);

    // Reset mid-burst
    ready_force = 1'b0;
    for (int i = 0; i < 21; i++) write(8'(8'h80 + i), i == 0);
    ready_force = 1'b1;
    cyc();
    chk("mid_count", 32'(count), 32'd20);
    chk("mid_strobe", 32'(uart_tx_strobe), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_strobe", 32'(uart_tx_strobe), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_drop", 32'(drop_count), 32'd0);
    cyc();
    chk("mrst_next_strobe", 32'(uart_tx_strobe), 32'd0);

    // drop_count saturation
    ready_force = 1'b0;
    for (int i = 0; i < 64; i++) write(8'(i), 1'b0);
    wr_strobe = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      wr_data = 8'(i);
      cyc();
      if (i == 254) chk("drop_254", 32'(drop_count), 32'd254);
      if (i == 255) chk("drop_255", 32'(drop_count), 32'd255);
    end
    wr_strobe = 1'b0;
    chk("drop_sat", 32'(drop_count), 32'd255);
    chk("sat_ovf", 32'(overflow), 32'd1);
    chk("sat_count", 32'(count), 32'd64);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("end_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
